// File: rtl/serial_frame_rx_if.sv
// -----------------------------------------------------------------------------
// serial_frame_rx_if
// Output handshake bundle of the serial frame receiver.
//   dout       : received data word (WIDTH bits)
//   dout_valid : dout holds an unconsumed word
//   dout_ready : consumer accepts dout when dout_valid && dout_ready
// Modports:
//   master : the receiver (drives dout/dout_valid, reads dout_ready)
//   slave  : the consumer (reads dout/dout_valid, drives dout_ready)
// -----------------------------------------------------------------------------
interface serial_frame_rx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;

    modport master (
        output dout,
        output dout_valid,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        output dout_ready
    );
endinterface

// File: rtl/serial_frame_rx.sv
// -----------------------------------------------------------------------------
// serial_frame_rx
// Receives framed, LSB-first serial words from the registered bit stream of the
// upstream flip-flop and presents them as WIDTH-bit words on a valid/ready
// handshake. Frame: start bit 0, WIDTH data bits, stop bit 1; one bit is taken
// per cycle with sample_en=1.
// Ports:
//   clk       : system clock, rising edge
//   reset     : synchronous active-low reset
//   sin       : serial data, idles at 1
//   sample_en : bit-sample strobe
//   err_clr   : clears the sticky overrun flag
//   frame_err : one-cycle pulse, stop bit sampled as 0
//   overrun   : sticky, a completed word was dropped (buffer full)
//   out_if    : dout / dout_valid / dout_ready handshake (master side)
// -----------------------------------------------------------------------------
module serial_frame_rx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sin,
    input  logic                 sample_en,
    input  logic                 err_clr,
    output logic                 frame_err,
    output logic                 overrun,
    serial_frame_rx_if.master    out_if
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic               pend_q, pend_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               valid_q, valid_d;
    logic               ferr_q, ferr_d;
    logic               ovr_q, ovr_d;

    logic [WIDTH-1:0]   bit_sel;
    logic               buf_free;
    logic               ovr_set;

    // One-hot decode of the bit counter: selects the shift-register bit that
    // the current data sample lands in.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit_sel
            assign bit_sel[gi] = (cnt_q == CNT_W'(gi));
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        pend_d   = pend_q;
        dout_d   = dout_q;
        valid_d  = valid_q;
        ferr_d   = 1'b0;
        ovr_d    = ovr_q;
        ovr_set  = 1'b0;
        buf_free = !valid_q || out_if.dout_ready;

        if (valid_q && out_if.dout_ready) begin
            valid_d = 1'b0;
        end

        // A good stop bit only marks the word as pending; it is handed to the
        // output buffer on the following edge, which gives the one-clock gap
        // between the stop sample and dout_valid. shreg is still intact here
        // because the cycle after STOP is always IDLE.
        if (pend_q) begin
            pend_d = 1'b0;
            if (buf_free) begin
                dout_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end

        if (sample_en) begin
            case (state_q)
                IDLE: begin
                    if (!sin) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    shreg_d = (shreg_q & ~bit_sel) | (bit_sel & {WIDTH{sin}});
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = STOP;
                    end
                end
                STOP: begin
                    // The stop sample is consumed here and never re-read as a
                    // start bit.
                    state_d = IDLE;
                    if (sin) begin
                        pend_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Set wins over clear when both happen in the same cycle.
        if (err_clr) begin
            ovr_d = 1'b0;
        end
        if (ovr_set) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            pend_q  <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            pend_q  <= pend_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_if.dout       = dout_q;
    assign out_if.dout_valid = valid_q;
    assign frame_err         = ferr_q;
    assign overrun           = ovr_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
module tb_serial_frame_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset0, sin0, se0, clr0, ferr0, ovr0;
    logic reset1, sin1, se1, clr1, ferr1, ovr1;

    serial_frame_rx_if #(.WIDTH(8)) if0 ();
    serial_frame_rx_if #(.WIDTH(2)) if1 ();

    serial_frame_rx #(.WIDTH(8), .CNT_W(5)) dut0 (
        .clk       (clk),
        .reset     (reset0),
        .sin       (sin0),
        .sample_en (se0),
        .err_clr   (clr0),
        .frame_err (ferr0),
        .overrun   (ovr0),
        .out_if    (if0.master)
    );

    serial_frame_rx #(.WIDTH(2), .CNT_W(2)) dut1 (
        .clk       (clk),
        .reset     (reset1),
        .sin       (sin1),
        .sample_en (se1),
        .err_clr   (clr1),
        .frame_err (ferr1),
        .overrun   (ovr1),
        .out_if    (if1.master)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: a frame is the list of samples taken since the line
    // was first seen low; once WIDTH+2 samples are collected the word and the
    // stop bit are read out of it.
    int          wid[2] = '{8, 2};
    logic [33:0] m_bits[2];
    int          m_cnt[2];
    logic [31:0] m_word[2];
    logic        m_pend[2];
    logic [31:0] m_dout[2];
    logic        m_valid[2];
    logic        m_ferr[2];
    logic        m_ovr[2];

    typedef struct packed {
        logic s;
        logic se;
    } slot_t;
    slot_t sched[$];

    task automatic model_edge(input int k, input logic rst, input logic se,
                              input logic s, input logic rdy, input logic clr);
        logic        free;
        logic        ovr_set;
        logic        nferr;
        logic [33:0] mask;
        if (!rst) begin
            m_bits[k] = '0; m_cnt[k] = 0; m_word[k] = '0; m_pend[k] = 1'b0;
            m_dout[k] = '0; m_valid[k] = 1'b0; m_ferr[k] = 1'b0; m_ovr[k] = 1'b0;
        end else begin
            free    = !m_valid[k] || rdy;
            ovr_set = 1'b0;
            nferr   = 1'b0;
            if (m_valid[k] && rdy) m_valid[k] = 1'b0;
            if (m_pend[k]) begin
                if (free) begin
                    m_dout[k]  = m_word[k];
                    m_valid[k] = 1'b1;
                end else begin
                    ovr_set = 1'b1;
                end
                m_pend[k] = 1'b0;
            end
            if (se && !(m_cnt[k] == 0 && s)) begin
                m_bits[k][m_cnt[k]] = s;
                m_cnt[k]++;
                if (m_cnt[k] == wid[k] + 2) begin
                    mask = (34'd1 << wid[k]) - 34'd1;
                    if (m_bits[k][wid[k] + 1]) begin
                        m_pend[k] = 1'b1;
                        m_word[k] = 32'((m_bits[k] >> 1) & mask);
                    end else begin
                        nferr = 1'b1;
                    end
                    m_cnt[k] = 0;
                end
            end
            if (clr) m_ovr[k] = 1'b0;
            if (ovr_set) m_ovr[k] = 1'b1;
            m_ferr[k] = nferr;
        end
    endtask

    // Advance one clock: the model consumes the inputs the DUTs are about to
    // sample, then the bench moves to the next falling edge.
    task automatic step();
        model_edge(0, reset0, se0, sin0, if0.dout_ready, clr0);
        model_edge(1, reset1, se1, sin1, if1.dout_ready, clr1);
        @(negedge clk);
    endtask

    task automatic sched_bit(input logic b, input int period);
        for (int p = 0; p < period; p++) begin
            if (p == period - 1) sched.push_back({b, 1'b1});
            else                 sched.push_back({1'($urandom_range(0, 1)), 1'b0});
        end
    endtask

    task automatic sched_frame(input int w, input logic [31:0] word,
                               input logic stop, input int period);
        sched_bit(1'b0, period);
        for (int i = 0; i < w; i++) sched_bit(word[i], period);
        sched_bit(stop, period);
    endtask

    task automatic sched_idle(input int n, input logic se);
        for (int i = 0; i < n; i++) sched.push_back({1'b1, se});
    endtask

    task automatic test_reset();
        slot_t       sl;
        logic [7:0]  word;
        int          vcount;
        logic [7:0]  cap;
        reset0 = 1'b0; reset1 = 1'b0;
        sin0 = 1'b0; se0 = 1'b1; sin1 = 1'b0; se1 = 1'b1;
        if0.dout_ready = 1'b1; if1.dout_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if ({if0.dout, if0.dout_valid, ferr0, ovr0} !== 11'd0) begin
                bad++;
                $display("FAIL reset_w8 got=%h required=000", {if0.dout, if0.dout_valid, ferr0, ovr0});
            end
            total++;
            if ({if1.dout, if1.dout_valid, ferr1, ovr1} !== 5'd0) begin
                bad++;
                $display("FAIL reset_w2 got=%h required=00", {if1.dout, if1.dout_valid, ferr1, ovr1});
            end
        end
        // Release with sin still low: that first sample is the start bit.
        reset0 = 1'b1; reset1 = 1'b1; sin1 = 1'b1; se1 = 1'b0;
        word = 8'($urandom_range(0, 255));
        sched.push_back({1'b0, 1'b1});
        for (int i = 0; i < 8; i++) sched.push_back({word[i], 1'b1});
        sched.push_back({1'b1, 1'b1});
        sched_idle(3, 1'b1);
        vcount = 0; cap = '0;
        while (sched.size() > 0) begin
            sl = sched.pop_front(); sin0 = sl.s; se0 = sl.se;
            step();
            total++;
            if ({if0.dout, if0.dout_valid, ferr0, ovr0} !== {m_dout[0][7:0], m_valid[0], m_ferr[0], m_ovr[0]}) begin
                bad++;
                $display("FAIL reset_release_model got=%h required=%h", {if0.dout, if0.dout_valid, ferr0, ovr0},
                         {m_dout[0][7:0], m_valid[0], m_ferr[0], m_ovr[0]});
            end
            if (if0.dout_valid === 1'b1) begin vcount++; cap = if0.dout; end
        end
        total++;
        if (vcount != 1 || cap !== word) begin
            bad++;
            $display("FAIL reset_first_start got=%h/%0d required=%h/1", cap, vcount, word);
        end
    endtask

    task automatic test_basic();
        slot_t sl;
        int    c;
        c = 0;
        if0.dout_ready = 1'b1; clr0 = 1'b0;
        sched_frame(8, 32'hA5, 1'b1, 1);
        sched_idle(4, 1'b1);
        while (sched.size() > 0) begin
            sl = sched.pop_front(); sin0 = sl.s; se0 = sl.se;
            step();
            c++;
            total++;
            if ({if0.dout, if0.dout_valid, ferr0, ovr0} !== {m_dout[0][7:0], m_valid[0], m_ferr[0], m_ovr[0]}) begin
                bad++;
                $display("FAIL basic_model cyc=%0d got=%h required=%h", c, {if0.dout, if0.dout_valid, ferr0, ovr0},
                         {m_dout[0][7:0], m_valid[0], m_ferr[0], m_ovr[0]});
            end
            total++;
            // Start sampled on the first step's edge; dout_valid 10 edges later.
            if (c == 11) begin
                if ({if0.dout, if0.dout_valid, ferr0} !== {8'hA5, 1'b1, 1'b0}) begin
                    bad++;
                    $display("FAIL basic_word cyc=%0d got=%h/%b required=a5/1", c, if0.dout, if0.dout_valid);
                end
            end else if (if0.dout_valid !== 1'b0 || ferr0 !== 1'b0) begin
                bad++;
                $display("FAIL basic_quiet cyc=%0d valid=%b ferr=%b required=0/0", c, if0.dout_valid, ferr0);
            end
        end
    endtask

    task automatic test_frame_err();
        slot_t      sl;
        int         fcount, vcount;
        logic [7:0] cap;
        fcount = 0; vcount = 0; cap = '0;
        if0.dout_ready = 1'b1;
        sched_frame(8, 32'h3C, 1'b0, 1);
        sched_frame(8, 32'h81, 1'b1, 1);
        sched_idle(4, 1'b1);
        while (sched.size() > 0) begin
            sl = sched.pop_front(); sin0 = sl.s; se0 = sl.se;
            step();
            total++;
            if ({if0.dout, if0.dout_valid, ferr0, ovr0} !== {m_dout[0][7:0], m_valid[0], m_ferr[0], m_ovr[0]}) begin
                bad++;
                $display("FAIL frame_err_model got=%h required=%h", {if0.dout, if0.dout_valid, ferr0, ovr0},
                         {m_dout[0][7:0], m_valid[0], m_ferr[0], m_ovr[0]});
            end
            if (ferr0 === 1'b1) fcount++;
            if (if0.dout_valid === 1'b1) begin vcount++; cap = if0.dout; end
        end
        total++;
        if (fcount != 1 || vcount != 1 || cap !== 8'h81) begin
            bad++;
            $display("FAIL frame_err_counts ferr=%0d valid=%0d dout=%h required=1/1/81", fcount, vcount, cap);
        end
    endtask

    task automatic test_overrun();
        slot_t sl;
        if0.dout_ready = 1'b0; clr0 = 1'b0;
        sched_frame(8, 32'h3C, 1'b1, 1);
        sched_frame(8, 32'hC3, 1'b1, 1);
        sched_idle(4, 1'b1);
        while (sched.size() > 0) begin
            sl = sched.pop_front(); sin0 = sl.s; se0 = sl.se;
            step();
            total++;
            if ({if0.dout, if0.dout_valid, ferr0, ovr0} !== {m_dout[0][7:0], m_valid[0], m_ferr[0], m_ovr[0]}) begin
                bad++;
                $display("FAIL overrun_model got=%h required=%h", {if0.dout, if0.dout_valid, ferr0, ovr0},
                         {m_dout[0][7:0], m_valid[0], m_ferr[0], m_ovr[0]});
            end
        end
        total++;
        if ({if0.dout, if0.dout_valid, ovr0} !== {8'h3C, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL overrun_set got=%h/%b/%b required=3c/1/1", if0.dout, if0.dout_valid, ovr0);
        end
        clr0 = 1'b1;
        step();
        clr0 = 1'b0;
        total++;
        if ({ovr0, if0.dout_valid} !== 2'b01) begin
            bad++;
            $display("FAIL overrun_clear ovr=%b valid=%b required=0/1", ovr0, if0.dout_valid);
        end
        if0.dout_ready = 1'b1;
        step();
        total++;
        if ({if0.dout, if0.dout_valid} !== {8'h3C, 1'b0}) begin
            bad++;
            $display("FAIL overrun_drain got=%h/%b required=3c/0", if0.dout, if0.dout_valid);
        end
    endtask

    task automatic test_strobe();
        slot_t      sl;
        int         vcount;
        logic [7:0] cap;
        vcount = 0; cap = '0;
        if0.dout_ready = 1'b1;
        sched_frame(8, 32'h5A, 1'b1, 3);
        sched_idle(6, 1'b0);
        while (sched.size() > 0) begin
            sl = sched.pop_front(); sin0 = sl.s; se0 = sl.se;
            step();
            total++;
            if ({if0.dout, if0.dout_valid, ferr0, ovr0} !== {m_dout[0][7:0], m_valid[0], m_ferr[0], m_ovr[0]}) begin
                bad++;
                $display("FAIL strobe_model got=%h required=%h", {if0.dout, if0.dout_valid, ferr0, ovr0},
                         {m_dout[0][7:0], m_valid[0], m_ferr[0], m_ovr[0]});
            end
            if (if0.dout_valid === 1'b1) begin vcount++; cap = if0.dout; end
        end
        total++;
        if (vcount != 1 || cap !== 8'h5A) begin
            bad++;
            $display("FAIL strobe_word got=%h/%0d required=5a/1", cap, vcount);
        end
    endtask

    task automatic test_mid_reset();
        slot_t       sl;
        int          vcount;
        logic [7:0]  cap;
        logic [1:0]  got2[$];
        if0.dout_ready = 1'b1; if1.dout_ready = 1'b1;
        // WIDTH=8: start + 4 data bits, then reset.
        sched.push_back({1'b0, 1'b1});
        sched.push_back({1'b1, 1'b1}); sched.push_back({1'b0, 1'b1});
        sched.push_back({1'b1, 1'b1}); sched.push_back({1'b1, 1'b1});
        while (sched.size() > 0) begin
            sl = sched.pop_front(); sin0 = sl.s; se0 = sl.se;
            step();
        end
        reset0 = 1'b0; sin0 = 1'b0; se0 = 1'b1;
        step();
        reset0 = 1'b1;
        total++;
        if ({if0.dout, if0.dout_valid, ferr0, ovr0} !== 11'd0) begin
            bad++;
            $display("FAIL mid_reset_w8 got=%h required=000", {if0.dout, if0.dout_valid, ferr0, ovr0});
        end
        vcount = 0; cap = '0;
        sched_frame(8, 32'hF0, 1'b1, 1);
        sched_idle(3, 1'b1);
        while (sched.size() > 0) begin
            sl = sched.pop_front(); sin0 = sl.s; se0 = sl.se;
            step();
            total++;
            if ({if0.dout, if0.dout_valid, ferr0, ovr0} !== {m_dout[0][7:0], m_valid[0], m_ferr[0], m_ovr[0]}) begin
                bad++;
                $display("FAIL mid_reset_model got=%h required=%h", {if0.dout, if0.dout_valid, ferr0, ovr0},
                         {m_dout[0][7:0], m_valid[0], m_ferr[0], m_ovr[0]});
            end
            if (if0.dout_valid === 1'b1) begin vcount++; cap = if0.dout; end
        end
        total++;
        if (vcount != 1 || cap !== 8'hF0) begin
            bad++;
            $display("FAIL mid_reset_f0 got=%h/%0d required=f0/1", cap, vcount);
        end
        // WIDTH=2: start + 1 data bit, reset, then frames 3 and 0.
        sched.push_back({1'b0, 1'b1}); sched.push_back({1'b0, 1'b1});
        while (sched.size() > 0) begin
            sl = sched.pop_front(); sin1 = sl.s; se1 = sl.se;
            step();
        end
        reset1 = 1'b0; sin1 = 1'b1; se1 = 1'b1;
        step();
        reset1 = 1'b1;
        total++;
        if ({if1.dout, if1.dout_valid, ferr1, ovr1} !== 5'd0) begin
            bad++;
            $display("FAIL mid_reset_w2 got=%h required=00", {if1.dout, if1.dout_valid, ferr1, ovr1});
        end
        sched_frame(2, 32'h3, 1'b1, 1);
        sched_frame(2, 32'h0, 1'b1, 1);
        sched_idle(3, 1'b1);
        while (sched.size() > 0) begin
            sl = sched.pop_front(); sin1 = sl.s; se1 = sl.se;
            step();
            total++;
            if ({if1.dout, if1.dout_valid, ferr1, ovr1} !== {m_dout[1][1:0], m_valid[1], m_ferr[1], m_ovr[1]}) begin
                bad++;
                $display("FAIL w2_model got=%h required=%h", {if1.dout, if1.dout_valid, ferr1, ovr1},
                         {m_dout[1][1:0], m_valid[1], m_ferr[1], m_ovr[1]});
            end
            if (if1.dout_valid === 1'b1) got2.push_back(if1.dout);
        end
        sin1 = 1'b1; se1 = 1'b0;
        total++;
        if (got2.size() != 2 || got2[0] !== 2'd3 || got2[1] !== 2'd0 || ovr1 !== 1'b0) begin
            bad++;
            $display("FAIL w2_words n=%0d ovr=%b required=2 words 3,0 ovr=0", got2.size(), ovr1);
        end
    endtask

    task automatic test_back_to_back();
        slot_t      sl;
        logic [7:0] a, b;
        logic [7:0] got[$];
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        if0.dout_ready = 1'b1;
        sched_frame(8, 32'(a), 1'b1, 1);
        sched_frame(8, 32'(b), 1'b1, 1);
        sched_idle(3, 1'b1);
        while (sched.size() > 0) begin
            sl = sched.pop_front(); sin0 = sl.s; se0 = sl.se;
            step();
            total++;
            if ({if0.dout, if0.dout_valid, ferr0, ovr0} !== {m_dout[0][7:0], m_valid[0], m_ferr[0], m_ovr[0]}) begin
                bad++;
                $display("FAIL b2b_model got=%h required=%h", {if0.dout, if0.dout_valid, ferr0, ovr0},
                         {m_dout[0][7:0], m_valid[0], m_ferr[0], m_ovr[0]});
            end
            if (if0.dout_valid === 1'b1) got.push_back(if0.dout);
        end
        total++;
        if (got.size() != 2 || got[0] !== a || got[1] !== b || ovr0 !== 1'b0) begin
            bad++;
            $display("FAIL b2b_words n=%0d ovr=%b required=2 words %h,%h ovr=0", got.size(), ovr0, a, b);
        end
    endtask

    task automatic test_random();
        slot_t sl;
        int    c;
        c = 0;
        for (int f = 0; f < 40; f++) begin
            sched_frame(8, 32'($urandom_range(0, 255)), 1'($urandom_range(0, 7) != 0),
                        int'($urandom_range(1, 3)));
            for (int g = int'($urandom_range(0, 3)); g > 0; g--)
                sched.push_back({1'b1, 1'($urandom_range(0, 1))});
        end
        while (sched.size() > 0) begin
            sl = sched.pop_front(); sin0 = sl.s; se0 = sl.se;
            if0.dout_ready = 1'($urandom_range(0, 3) != 0);
            clr0 = 1'($urandom_range(0, 15) == 0);
            step();
            c++;
            total++;
            if ({if0.dout, if0.dout_valid, ferr0, ovr0} !== {m_dout[0][7:0], m_valid[0], m_ferr[0], m_ovr[0]}) begin
                bad++;
                $display("FAIL random_model cyc=%0d got=%h required=%h", c, {if0.dout, if0.dout_valid, ferr0, ovr0},
                         {m_dout[0][7:0], m_valid[0], m_ferr[0], m_ovr[0]});
            end
        end
        if0.dout_ready = 1'b1; clr0 = 1'b0; sin0 = 1'b1; se0 = 1'b0;
    endtask

    initial begin
        reset0 = 1'b0; sin0 = 1'b1; se0 = 1'b0; clr0 = 1'b0; if0.dout_ready = 1'b0;
        reset1 = 1'b0; sin1 = 1'b1; se1 = 1'b0; clr1 = 1'b0; if1.dout_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_frame_err();
        test_overrun();
        test_strobe();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Downstream stage of the synchronous D flip-flop (`dffsyn`) register stage.
- Consumes the registered 1-bit serial stream (`q`) and assembles framed, LSB-first words into a WIDTH-bit parallel output.
- Output uses a valid/ready handshake.
- Flags framing errors and overruns so the consuming logic can drop bad data.

Parameters:
- WIDTH, 8, number of data bits per frame (2..32)
- CNT_W, 5, width of the internal bit counter; must satisfy 2^CNT_W > WIDTH

Ports:
- clk  input  1  system clock; all logic updates on its rising edge
- reset  input  1  synchronous, active-low reset; sampled on rising clk
- sin  input  1  serial data from the upstream flip-flop q; line idles at 1
- sample_en  input  1  bit-sample strobe; sin is examined only in cycles where sample_en=1
- dout  output  WIDTH  received data word
- dout_valid  output  1  dout holds an unconsumed word
- dout_ready  input  1  consumer accepts dout when dout_valid=1 and dout_ready=1
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0
- overrun  output  1  sticky: a completed word was dropped because the buffer was full
- err_clr  input  1  clears overrun

Behaviour:
- Reset (reset=0 at a rising clk edge):
  - state=IDLE, bit counter=0, shift register=0.
  - dout=0, dout_valid=0, frame_err=0, overrun=0.
  - Reset overrides every other input, including mid-frame; any partial frame is discarded.
- Frame format: start bit 0, then WIDTH data bits LSB first, then stop bit 1. One bit per sample_en=1 cycle.
- Cycles with sample_en=0 leave state, counter and shift register unchanged.
- FSM states: IDLE, DATA, STOP.
  - IDLE: when sample_en=1 and sin=0, go to DATA with counter=0. When sin=1, stay in IDLE.
  - DATA: when sample_en=1, write shreg[counter]=sin and increment counter. When counter==WIDTH-1 at that sample, go to STOP.
  - STOP: when sample_en=1, always return to IDLE. The stop sample is never reinterpreted as a start bit.
    - sin=1 and buffer free: dout<=shreg and dout_valid<=1.
    - sin=1 and buffer occupied: keep the old dout, discard the new word, set overrun=1.
    - sin=0: assert frame_err for exactly the next cycle and discard the word; dout and dout_valid are unchanged.
- Buffer-free rule: the buffer is free in a cycle if dout_valid=0, or if dout_valid=1 and dout_ready=1 in that cycle. A simultaneous handshake plus a new word loads the new word with dout_valid kept at 1.
- Handshake:
  - dout_valid stays 1, and dout stays stable, until a cycle with dout_ready=1.
  - The following cycle has dout_valid=0, unless a new word is loaded in that same cycle.
  - dout_ready while dout_valid=0 has no effect.
- Latency: dout_valid rises on the clock edge after the edge that samples the stop bit. With sample_en tied high, this is WIDTH+2 clocks after the start-bit sample edge.
- overrun:
  - Cleared only by err_clr=1 (or reset).
  - If err_clr and a new overrun event occur in the same cycle, set wins (overrun=1).
- frame_err is never sticky. Two consecutive bad frames give two separate one-cycle pulses.
- dout holds its last value after it is consumed; it is not cleared.

Test Plan (WIDTH=8 unless noted):
1. Reset: hold reset=0 for 2 clks with sin=0 and sample_en=1 -> dout=0x00, dout_valid=0, frame_err=0, overrun=0. The first sample after reset is released is treated as a start bit from IDLE.
2. Basic frame: sample_en=1, dout_ready=1; drive sin = 0, then 1,0,1,0,0,1,0,1, then stop 1 -> dout=0xA5 and dout_valid=1 for exactly one cycle, 10 clks after the start-bit edge; frame_err=0.
3. Framing error: send 0x3C with stop bit 0 -> frame_err=1 for exactly one cycle, dout_valid stays 0. The next valid frame 0x81 is received correctly.
4. Overrun:
   - Hold dout_ready=0 and send 0x3C then 0xC3 -> dout=0x3C, dout_valid=1, overrun=1.
   - Pulse err_clr -> overrun=0.
   - Raise dout_ready -> handshake completes and dout_valid drops the next cycle.
5. Strobed sampling: sample_en=1 every 3rd clk, each sin bit held for 3 clks, frame 0x5A -> dout=0x5A. The bench also toggles sin in sample_en=0 cycles and confirms it has no effect.
6. Mid-frame reset and boundaries:
   - Assert reset=0 after 4 data bits of a frame -> returns to IDLE with outputs at reset values; the next frame 0xF0 is received correctly.
   - Repeat with WIDTH=2 and frames 0x3 and 0x0.
   - Back-to-back frames with dout_ready=1 held through the stop-bit cycle -> both words delivered, overrun=0.
